// File: rtl/pager_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pager_arbiter
// Purpose  : Round-robin arbiter that serialises one requester's page code
//            onto a pager line as a SYNC + DATA + GAP frame.
// Revision : 1.0 - initial release
// ============================================================================
module pager_arbiter #(
    parameter int          N_REQ   = 4,
    parameter int          CODE_W  = 4,
    parameter logic [3:0]  SYNC    = 4'b0011,
    parameter int          GAP_CYC = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*CODE_W-1:0]   code,
    output logic [N_REQ-1:0]          gnt,
    output logic [1:0]                gnt_id,
    output logic                      x,
    output logic                      busy,
    output logic                      done
);

    localparam int               FRAME_W     = 4 + CODE_W;
    localparam int               CNT_W       = 8;
    localparam logic [CNT_W-1:0] C_SYNC_LAST = CNT_W'(3);
    localparam logic [CNT_W-1:0] C_DATA_LAST = CNT_W'(CODE_W - 1);
    localparam logic [CNT_W-1:0] C_GAP_LAST  = CNT_W'(GAP_CYC - 1);
    localparam logic [1:0]       C_ID_RST    = 2'(N_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_DATA = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [FRAME_W-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]     cnt_q,   cnt_d;
    logic [N_REQ-1:0]     gnt_q,   gnt_d;
    logic [1:0]           gnt_id_q, gnt_id_d;
    logic                 x_q,     x_d;
    logic                 busy_q,  busy_d;
    logic                 done_q,  done_d;

    logic                 w_found;
    logic [1:0]           w_winner;
    logic [1:0]           w_idx;
    logic [CODE_W-1:0]    w_code;

    // gnt_id doubles as the round-robin pointer: search starts just above it.
    always_comb begin
        w_found  = 1'b0;
        w_winner = gnt_id_q;
        w_idx    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_idx = 2'((int'(gnt_id_q) + k) % N_REQ);
            if (!w_found && req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    assign w_code = code[w_winner*CODE_W +: CODE_W];

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        gnt_d    = '0;
        gnt_id_d = gnt_id_q;
        x_d      = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (w_found) begin
                    gnt_d    = N_REQ'(1) << w_winner;
                    gnt_id_d = w_winner;
                    // First sync bit leaves now; the rest of the frame is queued.
                    x_d      = SYNC[3];
                    shreg_d  = {SYNC[2:0], w_code, 1'b0};
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = ST_SYNC;
                end
            end

            ST_SYNC: begin
                x_d     = shreg_q[FRAME_W-1];
                shreg_d = shreg_q << 1;
                if (cnt_q == C_SYNC_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_DATA: begin
                if (cnt_q == C_DATA_LAST) begin
                    cnt_d   = '0;
                    shreg_d = '0;
                    state_d = ST_GAP;
                end else begin
                    x_d     = shreg_q[FRAME_W-1];
                    shreg_d = shreg_q << 1;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end

            ST_GAP: begin
                if (cnt_q == C_GAP_LAST) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
            gnt_q    <= '0;
            gnt_id_q <= C_ID_RST;
            x_q      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            x_q      <= x_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign gnt    = gnt_q;
    assign gnt_id = gnt_id_q;
    assign x      = x_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_pager_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pager_arbiter
// Purpose  : Self-checking bench for pager_arbiter against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pager_arbiter;

    localparam int         N      = 4;
    localparam int         CW     = 4;
    localparam int         GAP    = 2;
    localparam int         FL     = 4 + CW + GAP;
    localparam logic [3:0] SYNC_P = 4'b0011;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req = '0;
    logic [N*CW-1:0] code = '0;
    logic [N-1:0]  gnt;
    logic [1:0]    gnt_id;
    logic          x;
    logic          busy;
    logic          done;

    pager_arbiter #(
        .N_REQ  (N),
        .CODE_W (CW),
        .SYNC   (SYNC_P),
        .GAP_CYC(GAP)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .code  (code),
        .gnt   (gnt),
        .gnt_id(gnt_id),
        .x     (x),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Frame-level reference: a frame is a bit vector, m_pos is the cycle within it.
    int            m_pos;
    logic [FL-1:0] m_frame;
    logic [1:0]    m_last;
    logic [N-1:0]  m_gnt;
    logic [1:0]    m_id;
    logic          m_x, m_busy, m_done;
    bit            auto_drop = 1'b1;

    task automatic model_reset();
        m_pos = -1; m_frame = '0; m_last = 2'(N-1);
        m_gnt = '0; m_id = 2'(N-1); m_x = 1'b0; m_busy = 1'b0; m_done = 1'b0;
    endtask

    task automatic model_edge(input logic [N-1:0] r, input logic [N*CW-1:0] c);
        logic [2*N-1:0] dbl;
        int start, j, w;
        m_gnt  = '0;
        m_done = 1'b0;
        if (m_pos < 0) begin
            m_x = 1'b0; m_busy = 1'b0;
            if (r != '0) begin
                start = (int'(m_last) + 1) % N;
                dbl   = {r, r} >> start;
                j = 0;
                while (!dbl[j]) j++;
                w = (start + j) % N;
                m_gnt   = N'(1 << w);
                m_id    = 2'(w);
                m_last  = 2'(w);
                m_frame = {SYNC_P, c[w*CW +: CW], {GAP{1'b0}}};
                m_pos   = 0;
                m_x     = m_frame[FL-1];
                m_busy  = 1'b1;
            end
        end else begin
            m_pos++;
            if (m_pos == FL) begin
                m_pos = -1; m_done = 1'b1; m_busy = 1'b0; m_x = 1'b0;
            end else begin
                m_x = m_frame[FL-1-m_pos];
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge(req, code);
        @(negedge clk);
        if (auto_drop) req = req & ~m_gnt;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; req = '0; code = '0; auto_drop = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic settle();
        for (int i = 0; i < 3*FL && (m_pos >= 0 || m_done); i++) tick();
    endtask

    task automatic test_reset();
        model_reset();
        req = 4'b1111;
        @(negedge clk);
        n_checks++;
        if ({gnt, gnt_id, x, busy, done} !== {4'b0000, 2'd3, 3'b000}) begin
            n_fail++;
            $display("FAIL reset_values: got gnt=%b id=%0d x=%b busy=%b done=%b, want 0000/3/0/0/0",
                     gnt, gnt_id, x, busy, done);
        end
        tick();
        n_checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_blocks_grant: got gnt=%b busy=%b, want 0000/0", gnt, busy);
        end
        req = '0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({gnt, gnt_id, x, busy, done} !== {4'b0000, 2'd3, 3'b000}) begin
                n_fail++;
                $display("FAIL idle_hold: got gnt=%b id=%0d x=%b busy=%b done=%b, want 0000/3/0/0/0",
                         gnt, gnt_id, x, busy, done);
            end
        end
    endtask

    task automatic test_single();
        logic [9:0] xs;
        int busy_cnt, done_cnt, gnt_cnt;
        apply_reset();
        code[2*CW +: CW] = 4'b1001;
        req = 4'b0100;
        xs = '0; busy_cnt = 0; done_cnt = 0; gnt_cnt = 0;
        for (int k = 0; k < 14; k++) begin
            tick();
            if (k < 10) xs[9-k] = x;
            busy_cnt += int'(busy);
            done_cnt += int'(done);
            if (gnt != '0) gnt_cnt++;
            if (k == 0) begin
                n_checks++;
                if (gnt !== 4'b0100 || gnt_id !== 2'd2) begin
                    n_fail++;
                    $display("FAIL single_grant: got gnt=%b id=%0d, want 0100/2", gnt, gnt_id);
                end
            end
            n_checks++;
            if ({gnt, gnt_id, x, busy, done} !== {m_gnt, m_id, m_x, m_busy, m_done}) begin
                n_fail++;
                $display("FAIL single_model k=%0d: got %b/%0d/%b/%b/%b, want %b/%0d/%b/%b/%b",
                         k, gnt, gnt_id, x, busy, done, m_gnt, m_id, m_x, m_busy, m_done);
            end
        end
        n_checks++;
        if (xs !== 10'b0011100100) begin
            n_fail++;
            $display("FAIL single_xseq: got %b, want 0011100100", xs);
        end
        n_checks++;
        if (busy_cnt != 10 || done_cnt != 1 || gnt_cnt != 1 || gnt_id !== 2'd2) begin
            n_fail++;
            $display("FAIL single_counts: got busy=%0d done=%0d gnt=%0d id=%0d, want 10/1/1/2",
                     busy_cnt, done_cnt, gnt_cnt, gnt_id);
        end
    endtask

    task automatic test_round_robin();
        int order[$];
        int when[$];
        int exp_order[5] = '{0, 1, 2, 3, 0};
        apply_reset();
        auto_drop = 1'b0;
        req = 4'b1111;
        for (int cyc = 0; cyc < 80 && order.size() < 5; cyc++) begin
            tick();
            n_checks++;
            if ({gnt, gnt_id, x, busy, done} !== {m_gnt, m_id, m_x, m_busy, m_done}) begin
                n_fail++;
                $display("FAIL rr_model cyc=%0d: got %b/%0d/%b/%b/%b, want %b/%0d/%b/%b/%b",
                         cyc, gnt, gnt_id, x, busy, done, m_gnt, m_id, m_x, m_busy, m_done);
            end
            for (int j = 0; j < N; j++) if (gnt[j]) begin order.push_back(j); when.push_back(cyc); end
        end
        n_checks++;
        if (order.size() != 5) begin
            n_fail++;
            $display("FAIL rr_count: got %0d grants, want 5", order.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (order[i] != exp_order[i]) begin
                    n_fail++;
                    $display("FAIL rr_order[%0d]: got %0d, want %0d", i, order[i], exp_order[i]);
                end
            end
            for (int i = 1; i < 5; i++) begin
                n_checks++;
                if (when[i] - when[i-1] != FL + 1) begin
                    n_fail++;
                    $display("FAIL rr_spacing[%0d]: got %0d cycles, want %0d", i, when[i] - when[i-1], FL + 1);
                end
            end
        end
        req = '0;
        auto_drop = 1'b1;
        settle();
    endtask

    task automatic test_wrap_skip();
        int order[$];
        apply_reset();
        req = 4'b1000;
        tick();
        for (int j = 0; j < N; j++) if (gnt[j]) order.push_back(j);
        req = 4'b0101;
        for (int cyc = 0; cyc < 40 && order.size() < 3; cyc++) begin
            tick();
            n_checks++;
            if ({gnt, gnt_id, x, busy, done} !== {m_gnt, m_id, m_x, m_busy, m_done}) begin
                n_fail++;
                $display("FAIL wrap_model cyc=%0d: got %b/%0d/%b/%b/%b, want %b/%0d/%b/%b/%b",
                         cyc, gnt, gnt_id, x, busy, done, m_gnt, m_id, m_x, m_busy, m_done);
            end
            for (int j = 0; j < N; j++) if (gnt[j]) order.push_back(j);
        end
        n_checks++;
        if (order.size() != 3 || order[0] != 3 || order[1] != 0 || order[2] != 2) begin
            n_fail++;
            $display("FAIL wrap_order: got %p, want '{3, 0, 2}", order);
        end
        settle();
    endtask

    task automatic test_ignore_busy();
        int early_gnt;
        bit seen_done;
        apply_reset();
        req = 4'b0001;
        tick();
        for (int i = 0; i < 3; i++) tick();
        req = req | 4'b0010;
        early_gnt = 0; seen_done = 1'b0;
        for (int cyc = 0; cyc < 3*FL && !seen_done; cyc++) begin
            tick();
            if (gnt != '0) early_gnt++;
            if (done) seen_done = 1'b1;
        end
        n_checks++;
        if (!seen_done || early_gnt != 0) begin
            n_fail++;
            $display("FAIL busy_ignore: got done_seen=%0d grants_in_frame=%0d, want 1/0", seen_done, early_gnt);
        end
        tick();
        n_checks++;
        if (gnt !== 4'b0010 || gnt !== m_gnt) begin
            n_fail++;
            $display("FAIL busy_next_grant: got gnt=%b, want 0010", gnt);
        end
        settle();
    endtask

    task automatic test_code_change();
        logic [3:0] bits;
        apply_reset();
        code[0 +: CW] = 4'b1010;
        req = 4'b0001;
        bits = '0;
        for (int k = 0; k < FL; k++) begin
            tick();
            if (k == 1) code[0 +: CW] = 4'b0101;
            if (k >= 4 && k < 8) bits[7-k] = x;
            n_checks++;
            if ({gnt, gnt_id, x, busy, done} !== {m_gnt, m_id, m_x, m_busy, m_done}) begin
                n_fail++;
                $display("FAIL code_model k=%0d: got %b/%0d/%b/%b/%b, want %b/%0d/%b/%b/%b",
                         k, gnt, gnt_id, x, busy, done, m_gnt, m_id, m_x, m_busy, m_done);
            end
        end
        n_checks++;
        if (bits !== 4'b1010) begin
            n_fail++;
            $display("FAIL code_latched: got data %b, want 1010", bits);
        end
        settle();
    endtask

    task automatic test_mid_reset();
        int done_cnt;
        apply_reset();
        req = 4'b1000;
        for (int i = 0; i < 6; i++) tick();
        #2 rst = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if ({gnt, gnt_id, x, busy, done} !== {4'b0000, 2'd3, 3'b000}) begin
            n_fail++;
            $display("FAIL midreset_async: got gnt=%b id=%0d x=%b busy=%b done=%b, want 0000/3/0/0/0",
                     gnt, gnt_id, x, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
        req = 4'b0110;
        done_cnt = 0;
        tick();
        done_cnt += int'(done);
        n_checks++;
        if (gnt !== 4'b0010 || gnt_id !== 2'd1) begin
            n_fail++;
            $display("FAIL midreset_regrant: got gnt=%b id=%0d, want 0010/1", gnt, gnt_id);
        end
        for (int k = 1; k < FL; k++) begin
            tick();
            done_cnt += int'(done);
        end
        n_checks++;
        if (done_cnt != 0) begin
            n_fail++;
            $display("FAIL midreset_nodone: got %0d done pulses, want 0", done_cnt);
        end
        settle();
    endtask

    task automatic test_random();
        apply_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            if ($urandom_range(0, 3) == 0) req = req | N'($urandom);
            if ($urandom_range(0, 5) == 0) code = (N*CW)'($urandom);
            tick();
            n_checks++;
            if ({gnt, gnt_id, x, busy, done} !== {m_gnt, m_id, m_x, m_busy, m_done}) begin
                n_fail++;
                $display("FAIL random_model cyc=%0d: got %b/%0d/%b/%b/%b, want %b/%0d/%b/%b/%b",
                         cyc, gnt, gnt_id, x, busy, done, m_gnt, m_id, m_x, m_busy, m_done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_wrap_skip();
        test_ignore_busy();
        test_code_change();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
